// File: rtl/shim_spi_cfg_sync.sv
// SPI-domain receiver for AXI-written configuration words: toggle-synchronized request,
// range check, deferred apply of hardware-sensitive fields. Optional macro: SHIM_CFG_OFF_TIMEOUT_EN.
module shim_spi_cfg_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WINDOW  = 2048,
  parameter int MIN_CS_HIGH = 4,
  parameter int OFF_TIMEOUT = 65535
) (
  input  logic        spi_clk,
  input  logic        spi_rst,
  input  logic        req_tgl,
  input  logic        spi_off,
  input  logic        in_spi_en,
  input  logic        in_integ_en,
  input  logic [31:0] in_integ_window,
  input  logic [14:0] in_integ_thresh_avg,
  input  logic [7:0]  in_dac_n_cs_high,
  input  logic [7:0]  in_adc_n_cs_high,
  output logic        ack_tgl,
  output logic        spi_en,
  output logic        integ_en,
  output logic [31:0] integ_window,
  output logic [14:0] integ_thresh_avg,
  output logic [7:0]  dac_n_cs_high,
  output logic [7:0]  adc_n_cs_high,
  output logic        cfg_applied,
  output logic        cfg_rej,
  output logic [1:0]  cfg_err_code
);

  // Handshake: the AXI side toggles req_tgl with in_* already stable and keeps them stable
  // until it sees ack_tgl invert; each request gets exactly one ack_tgl inversion.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [31:0] MIN_WINDOW_W = 32'(MIN_WINDOW);
  localparam logic [7:0]  MIN_CS_W     = 8'(MIN_CS_HIGH);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, CHECK, APPLY_EN, WAIT_OFF, APPLY, ACK_OK, REJECT
  } state_t;

  state_t state_q, state_d;

  logic [SS-1:0] sync_q;
  logic          req_s;
  logic          req_seen;

  logic        sh_spi_en;
  logic        sh_integ_en;
  logic [31:0] sh_window;
  logic [14:0] sh_thresh;
  logic [7:0]  sh_dac;
  logic [7:0]  sh_adc;
  logic [1:0]  err_pend;

  logic win_bad, cs_bad, fields_eq, timeout_hit;

  assign req_s     = sync_q[SS-1];
  assign win_bad   = (sh_window < MIN_WINDOW_W);
  assign cs_bad    = (sh_dac < MIN_CS_W) || (sh_adc < MIN_CS_W);
  assign fields_eq = (sh_integ_en == integ_en) && (sh_window == integ_window) &&
                     (sh_thresh == integ_thresh_avg) && (sh_dac == dac_n_cs_high) &&
                     (sh_adc == adc_n_cs_high);

`ifdef SHIM_CFG_OFF_TIMEOUT_EN
  logic [15:0] off_cnt;
  assign timeout_hit = (off_cnt >= 16'(OFF_TIMEOUT - 1));

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      off_cnt <= '0;
    end else if (state_q == APPLY_EN) begin
      off_cnt <= '0;
    end else if (state_q == WAIT_OFF && !timeout_hit) begin
      off_cnt <= off_cnt + 16'd1;
    end
  end
`else
  // Never fires: WAIT_OFF waits for spi_off indefinitely in this build.
  assign timeout_hit = (OFF_TIMEOUT < 0);
`endif

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_s != req_seen) state_d = CAPTURE;
      CAPTURE:  state_d = CHECK;
      CHECK:    state_d = (win_bad || cs_bad) ? REJECT : APPLY_EN;
      APPLY_EN: state_d = fields_eq ? ACK_OK : WAIT_OFF;
      WAIT_OFF: begin
        if (spi_off)          state_d = APPLY;
        else if (timeout_hit) state_d = REJECT;
      end
      APPLY:    state_d = ACK_OK;
      ACK_OK:   state_d = IDLE;
      REJECT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      sync_q           <= '0;
      req_seen         <= 1'b0;
      ack_tgl          <= 1'b0;
      spi_en           <= 1'b0;
      integ_en         <= 1'b0;
      integ_window     <= MIN_WINDOW_W;
      integ_thresh_avg <= '0;
      dac_n_cs_high    <= MIN_CS_W;
      adc_n_cs_high    <= MIN_CS_W;
      cfg_applied      <= 1'b0;
      cfg_rej          <= 1'b0;
      cfg_err_code     <= 2'd0;
      sh_spi_en        <= 1'b0;
      sh_integ_en      <= 1'b0;
      sh_window        <= '0;
      sh_thresh        <= '0;
      sh_dac           <= '0;
      sh_adc           <= '0;
      err_pend         <= 2'd0;
    end else begin
      sync_q      <= {sync_q[SS-2:0], req_tgl};
      cfg_applied <= 1'b0;
      cfg_rej     <= 1'b0;
      case (state_q)
        CAPTURE: begin
          sh_spi_en   <= in_spi_en;
          sh_integ_en <= in_integ_en;
          sh_window   <= in_integ_window;
          sh_thresh   <= in_integ_thresh_avg;
          sh_dac      <= in_dac_n_cs_high;
          sh_adc      <= in_adc_n_cs_high;
          req_seen    <= req_s;
        end
        // Window is reported ahead of cs_high when both are out of range.
        CHECK:    err_pend <= win_bad ? 2'd1 : (cs_bad ? 2'd2 : 2'd0);
        APPLY_EN: spi_en <= sh_spi_en;
        WAIT_OFF: if (!spi_off && timeout_hit) err_pend <= 2'd3;
        APPLY: begin
          integ_en         <= sh_integ_en;
          integ_window     <= sh_window;
          integ_thresh_avg <= sh_thresh;
          dac_n_cs_high    <= sh_dac;
          adc_n_cs_high    <= sh_adc;
        end
        ACK_OK: begin
          cfg_applied  <= 1'b1;
          cfg_err_code <= 2'd0;
          ack_tgl      <= ~ack_tgl;
        end
        REJECT: begin
          cfg_rej      <= 1'b1;
          cfg_err_code <= err_pend;
          ack_tgl      <= ~ack_tgl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shim_spi_cfg_sync.sv
// Scoreboard bench for shim_spi_cfg_sync: a reference model predicts each request's outcome,
// the monitor pops and compares when cfg_applied/cfg_rej pulses.
module tb_shim_spi_cfg_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_tgl = 1'b0;
  logic        spi_off = 1'b1;
  logic        in_spi_en = 1'b0;
  logic        in_integ_en = 1'b0;
  logic [31:0] in_integ_window = 32'd0;
  logic [14:0] in_integ_thresh_avg = 15'd0;
  logic [7:0]  in_dac_n_cs_high = 8'd0;
  logic [7:0]  in_adc_n_cs_high = 8'd0;
  logic        ack_tgl, spi_en, integ_en, cfg_applied, cfg_rej;
  logic [31:0] integ_window;
  logic [14:0] integ_thresh_avg;
  logic [7:0]  dac_n_cs_high, adc_n_cs_high;
  logic [1:0]  cfg_err_code;

  shim_spi_cfg_sync #(
    .SYNC_STAGES(2), .MIN_WINDOW(2048), .MIN_CS_HIGH(4), .OFF_TIMEOUT(100)
  ) dut (
    .spi_clk(clk), .spi_rst(rst), .req_tgl(req_tgl), .spi_off(spi_off),
    .in_spi_en(in_spi_en), .in_integ_en(in_integ_en), .in_integ_window(in_integ_window),
    .in_integ_thresh_avg(in_integ_thresh_avg), .in_dac_n_cs_high(in_dac_n_cs_high),
    .in_adc_n_cs_high(in_adc_n_cs_high), .ack_tgl(ack_tgl), .spi_en(spi_en),
    .integ_en(integ_en), .integ_window(integ_window), .integ_thresh_avg(integ_thresh_avg),
    .dac_n_cs_high(dac_n_cs_high), .adc_n_cs_high(adc_n_cs_high),
    .cfg_applied(cfg_applied), .cfg_rej(cfg_rej), .cfg_err_code(cfg_err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rej;
    logic [1:0]  code;
    logic        spi_en;
    logic        integ_en;
    logic [31:0] win;
    logic [14:0] th;
    logic [7:0]  dac;
    logic [7:0]  adc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the applied outputs.
  logic        m_spi_en = 1'b0, m_integ_en = 1'b0;
  logic [31:0] m_win = 32'd2048;
  logic [14:0] m_th = 15'd0;
  logic [7:0]  m_dac = 8'd4, m_adc = 8'd4;

  int n_checks = 0;
  int n_fail = 0;
  int req_count = 0;
  int ack_edges = 0;
  logic ack_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: sampled 1 time unit after the active edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (ack_tgl != ack_prev) begin
        ack_edges++;
        check_val("pulse_with_ack", {31'd0, cfg_applied | cfg_rej}, 32'd1);
      end
      if (cfg_applied || cfg_rej) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_pulse", {31'd0, cfg_applied | cfg_rej}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("cfg_rej", {31'd0, cfg_rej}, {31'd0, e.rej});
          check_val("cfg_applied", {31'd0, cfg_applied}, {31'd0, ~e.rej});
          check_val("err_code", {30'd0, cfg_err_code}, {30'd0, e.code});
          check_val("spi_en", {31'd0, spi_en}, {31'd0, e.spi_en});
          check_val("integ_en", {31'd0, integ_en}, {31'd0, e.integ_en});
          check_val("window", integ_window, e.win);
          check_val("thresh", {17'd0, integ_thresh_avg}, {17'd0, e.th});
          check_val("dac_cs", {24'd0, dac_n_cs_high}, {24'd0, e.dac});
          check_val("adc_cs", {24'd0, adc_n_cs_high}, {24'd0, e.adc});
        end
      end
    end
    ack_prev = ack_tgl;
  end

  // Drives one request, predicts its outcome, and pushes the expectation.
  task automatic push_req(input logic se, input logic ie, input logic [31:0] w,
                          input logic [14:0] th, input logic [7:0] dac, input logic [7:0] adc,
                          input logic expect_timeout);
    exp_t e;
    @(negedge clk);
    in_spi_en = se; in_integ_en = ie; in_integ_window = w;
    in_integ_thresh_avg = th; in_dac_n_cs_high = dac; in_adc_n_cs_high = adc;
    e.rej = 1'b0;
    e.code = 2'd0;
    if (w < 32'd2048) begin
      e.rej = 1'b1; e.code = 2'd1;
    end else if (dac < 8'd4 || adc < 8'd4) begin
      e.rej = 1'b1; e.code = 2'd2;
    end else if (expect_timeout) begin
      e.rej = 1'b1; e.code = 2'd3; m_spi_en = se;
    end else begin
      m_spi_en = se; m_integ_en = ie; m_win = w; m_th = th; m_dac = dac; m_adc = adc;
    end
    e.spi_en = m_spi_en; e.integ_en = m_integ_en; e.win = m_win;
    e.th = m_th; e.dac = m_dac; e.adc = m_adc;
    exp_q.push_back(e);
    req_count++;
    @(negedge clk);
    req_tgl = ~req_tgl;
  endtask

  task automatic wait_acks;
    int cyc = 0;
    while (ack_edges < req_count && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("ack_timeout", ack_edges, req_count);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_spi_en", {31'd0, spi_en}, 32'd0);
    check_val("rst_integ_en", {31'd0, integ_en}, 32'd0);
    check_val("rst_window", integ_window, 32'd2048);
    check_val("rst_thresh", {17'd0, integ_thresh_avg}, 32'd0);
    check_val("rst_dac_cs", {24'd0, dac_n_cs_high}, 32'd4);
    check_val("rst_adc_cs", {24'd0, adc_n_cs_high}, 32'd4);
    check_val("rst_ack", {31'd0, ack_tgl}, 32'd0);
    check_val("rst_pulses", {30'd0, cfg_applied, cfg_rej}, 32'd0);
    check_val("rst_code", {30'd0, cfg_err_code}, 32'd0);

    // Plain apply with the system off.
    spi_off = 1'b1;
    push_req(1'b0, 1'b0, 32'd4096, 15'd100, 8'd6, 8'd6, 1'b0);
    wait_acks();
    check_val("ack_after_first", {31'd0, ack_tgl}, 32'd1);

    // Window and cs_high both bad: window reported.
    push_req(1'b1, 1'b1, 32'd1000, 15'd7, 8'd2, 8'd2, 1'b0);
    wait_acks();
    check_val("code_held", {30'd0, cfg_err_code}, 32'd1);
    push_req(1'b0, 1'b0, 32'd4096, 15'd100, 8'd3, 8'd6, 1'b0);
    wait_acks();

    // Only spi_en changes: applies without waiting for spi_off.
    spi_off = 1'b0;
    push_req(1'b1, 1'b0, 32'd4096, 15'd100, 8'd6, 8'd6, 1'b0);
    wait_acks();
    check_val("spi_en_on", {31'd0, spi_en}, 32'd1);

    // Deferred apply: spi_en drops, window held until spi_off rises.
    push_req(1'b0, 1'b0, 32'd8192, 15'd100, 8'd6, 8'd6, 1'b0);
    repeat (20) @(negedge clk);
    check_val("wait_spi_en", {31'd0, spi_en}, 32'd0);
    check_val("wait_window", integ_window, 32'd4096);
    check_val("wait_no_ack", ack_edges, req_count - 1);
    repeat (30) @(negedge clk);
    spi_off = 1'b1;
    wait_acks();

    // Second toggle while the first request sits in WAIT_OFF.
    spi_off = 1'b0;
    begin
      int edges0;
      edges0 = ack_edges;
      push_req(1'b0, 1'b1, 32'd16384, 15'd9, 8'd8, 8'd5, 1'b0);
      repeat (15) @(negedge clk);
      push_req(1'b0, 1'b1, 32'd16384, 15'd9, 8'd8, 8'd5, 1'b0);
      repeat (15) @(negedge clk);
      spi_off = 1'b1;
      wait_acks();
      repeat (20) @(negedge clk);
      check_val("two_acks", ack_edges - edges0, 32'd2);
    end

    // Randomized requests, system off.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047))
                                      : 32'($urandom_range(2048, 100000));
      push_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
               15'($urandom_range(0, 32767)), 8'($urandom_range(0, 9)),
               8'($urandom_range(0, 9)), 1'b0);
      wait_acks();
    end

`ifdef SHIM_CFG_OFF_TIMEOUT_EN
    spi_off = 1'b0;
    push_req(~m_spi_en, m_integ_en, 32'd32768, m_th, m_dac, m_adc, 1'b1);
    wait_acks();
    spi_off = 1'b1;
`endif

    repeat (10) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 32'd0);
    check_val("total_acks", ack_edges, req_count);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
